// File: rtl/mem_arbiter_if.sv
// Clock/reset bundle for the unified-memory arbiter.
// The reset line is active-low and sampled synchronously by the arbiter.
interface mem_arbiter_if;
  logic clk;
  logic reset;

  modport sink (input clk, input reset);
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one fixed-latency memory.
// Data wins contention unless fetch has lost STARVE arbitrations in a row.
module mem_arbiter #(
  parameter int unsigned N      = 32,
  parameter int unsigned LAT    = 2,
  parameter int unsigned STARVE = 2
) (
  mem_arbiter_if.sink  ctrl_bus,
  input  logic         i_req,
  input  logic [N-1:0] i_addr,
  output logic [N-1:0] i_rdata,
  output logic         i_ready,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_ready,
  output logic         m_en,
  output logic         m_we,
  output logic [N-1:0] m_addr,
  output logic [N-1:0] m_wdata,
  input  logic [N-1:0] m_rdata,
  output logic         busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned STV_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  logic clk;
  logic rst_n;
  assign clk   = ctrl_bus.clk;
  assign rst_n = ctrl_bus.reset;

  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [STV_W-1:0]   starve_q,  starve_d;
  owner_t             owner_q,   owner_d;
  logic [N-1:0]       addr_q,    addr_d;
  logic               we_q,      we_d;
  logic [N-1:0]       wdata_q,   wdata_d;
  logic [N-1:0]       i_rdata_q, i_rdata_d;
  logic [N-1:0]       d_rdata_q, d_rdata_d;
  logic               i_ready_q, i_ready_d;
  logic               d_ready_q, d_ready_d;
  logic               m_en_q,    m_en_d;
  logic               m_we_q,    m_we_d;
  logic               busy_q,    busy_d;
  logic               grant_i;

  // Next-state, arbitration, grant latching and registered-output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_i   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant_i = i_req && (!d_req || (starve_q == STV_MAX));
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
          if (grant_i) begin
            owner_d  = OWN_I;
            addr_d   = i_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            starve_d = '0;
          end else begin
            owner_d = OWN_D;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            // Fetch lost while asking: one step closer to forced priority
            if (i_req && (starve_q != STV_MAX)) begin
              starve_d = starve_q + STV_W'(1);
            end
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == OWN_D) begin
              d_rdata_d = m_rdata;
            end else begin
              i_rdata_d = m_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    m_en_d    = (state_d == ACCESS);
    m_we_d    = (state_d == ACCESS) && we_d;
    busy_d    = (state_d != IDLE);
    i_ready_d = (state_d == DONE) && (owner_d == OWN_I);
    d_ready_d = (state_d == DONE) && (owner_d == OWN_D);
  end

  // State register; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      starve_q  <= '0;
      owner_q   <= OWN_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      busy_q    <= busy_d;
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_ready = i_ready_q;
  assign d_rdata = d_rdata_q;
  assign d_ready = d_ready_q;
  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: predicted completions are queued at issue
// time and compared against each ready pulse.
module tb_mem_arbiter;

  localparam int unsigned N      = 32;
  localparam int unsigned LAT    = 2;
  localparam int unsigned STARVE = 2;

  logic clk = 1'b0;
  logic rst_n;

  logic         i_req;
  logic [N-1:0] i_addr;
  logic [N-1:0] i_rdata;
  logic         i_ready;
  logic         d_req;
  logic         d_we;
  logic [N-1:0] d_addr;
  logic [N-1:0] d_wdata;
  logic [N-1:0] d_rdata;
  logic         d_ready;
  logic         m_en;
  logic         m_we;
  logic [N-1:0] m_addr;
  logic [N-1:0] m_wdata;
  logic [N-1:0] m_rdata;
  logic         busy;

  mem_arbiter_if bus ();
  assign bus.clk   = clk;
  assign bus.reset = rst_n;

  mem_arbiter #(.N(N), .LAT(LAT), .STARVE(STARVE)) dut (
    .ctrl_bus (bus),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ready  (i_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Memory contents as a fixed function of the address
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C01_0004;
    return (a ^ 32'h5A5A_0000) + 32'h11;
  endfunction

  assign m_rdata = mem_model(m_addr);

  typedef struct {
    bit          is_d;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;
  int          n_cmp  = 0;
  int          n_err  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predict both rdata ports after this access completes
  task automatic expect_txn(input bit is_d, input bit we, input logic [31:0] addr);
    if (!is_d) last_i = mem_model(addr);
    else if (!we) last_d = mem_model(addr);
    sb.push_back('{is_d, last_i, last_d});
  endtask

  task automatic wait_done(output int lat, output int en, output int we,
                           output logic [31:0] a, output logic [31:0] w);
    lat = 0; en = 0; we = 0; a = '0; w = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (m_en === 1'b1 && en == 0) begin
        a = m_addr;
        w = m_wdata;
      end
      if (m_en === 1'b1) en++;
      if (m_we === 1'b1) we++;
      if (i_ready === 1'b1 || d_ready === 1'b1) return;
    end
    check("ready_timeout", 32'd1, 32'd0);
  endtask

  // Every ready pulse must match the oldest predicted completion
  always @(negedge clk) begin
    if (i_ready === 1'b1 || d_ready === 1'b1) begin
      check("ready_excl", 32'(i_ready & d_ready), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ready_port", 32'(d_ready), 32'(e.is_d));
        check("i_rdata", i_rdata, e.exp_i);
        check("d_rdata", d_rdata, e.exp_d);
      end
    end
  end

  initial begin
    int          lat, lat1, en, we, st;
    bit          win_i;
    logic [31:0] a, w;

    rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_i_ready", 32'(i_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_m_en",    32'(m_en),    32'd0);
    check("rst_m_we",    32'(m_we),    32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_m_addr",  m_addr,       32'd0);
    check("rst_m_wdata", m_wdata,      32'd0);
    check("rst_i_rdata", i_rdata,      32'd0);
    check("rst_d_rdata", d_rdata,      32'd0);

    // Lone fetch
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_req = 1'b1; i_addr = 32'h40;
    expect_txn(1'b0, 1'b0, 32'h40);
    wait_done(lat, en, we, a, w);
    check("fetch_lat",    32'(lat), 32'(LAT + 2));
    check("fetch_en",     32'(en),  32'(LAT));
    check("fetch_we",     32'(we),  32'd0);
    check("fetch_addr",   a,        32'h40);
    check("fetch_rdata",  i_rdata,  32'h8C01_0004);
    check("fetch_busy",   32'(busy), 32'd1);
    @(posedge clk); #1;
    i_req = 1'b0;

    // Load so the following store has a non-zero d_rdata to preserve
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    expect_txn(1'b1, 1'b0, 32'h80);
    wait_done(lat, en, we, a, w);
    check("load_lat",  32'(lat), 32'(LAT + 2));
    check("load_addr", a,        32'h80);
    @(posedge clk); #1;

    // Store
    d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    expect_txn(1'b1, 1'b1, 32'h100);
    wait_done(lat, en, we, a, w);
    check("store_lat",   32'(lat), 32'(LAT + 2));
    check("store_we",    32'(we),  32'(LAT));
    check("store_addr",  a,        32'h100);
    check("store_wdata", w,        32'hDEAD_BEEF);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("store_m_we_idle", 32'(m_we), 32'd0);
    check("hold_m_wdata",    m_wdata,   32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Contention: data first, fetch in the next IDLE
    i_req = 1'b1; i_addr = 32'h240;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    expect_txn(1'b1, 1'b0, 32'h200);
    expect_txn(1'b0, 1'b0, 32'h240);
    wait_done(lat1, en, we, a, w);
    check("cont_first_addr", a, 32'h200);
    @(posedge clk); #1;
    d_req = 1'b0;
    wait_done(lat, en, we, a, w);
    check("cont_second_addr", a, 32'h240);
    check("cont_cycles", 32'(lat1 + lat), 32'(2 * (LAT + 2)));
    @(posedge clk); #1;
    i_req = 1'b0;

    // Starvation: fetch held, data re-requests every IDLE; fetch won last, so count is 0
    st = 0;
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    for (int r = 0; r < 6; r++) begin
      win_i = (st == int'(STARVE));
      if (win_i) begin
        expect_txn(1'b0, 1'b0, i_addr);
        st = 0;
      end else begin
        expect_txn(1'b1, 1'b0, d_addr);
        if (st < int'(STARVE)) st++;
      end
      wait_done(lat, en, we, a, w);
      check("starve_lat",  32'(lat), 32'(LAT + 2));
      check("starve_addr", a, win_i ? i_addr : d_addr);
      @(posedge clk); #1;
      if (win_i) i_addr = i_addr + 32'd4;
      else d_addr = d_addr + 32'd4;
    end
    i_req = 1'b0; d_req = 1'b0;

    // Reset in the second ACCESS cycle of a load
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("abort_pre_m_en", 32'(m_en), 32'd1);
    @(posedge clk);
    last_i = '0; last_d = '0;
    @(negedge clk);
    check("abort_m_en",    32'(m_en),    32'd0);
    check("abort_d_ready", 32'(d_ready), 32'd0);
    check("abort_busy",    32'(busy),    32'd0);
    check("abort_d_rdata", d_rdata,      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Arbitration resumes right after release
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    expect_txn(1'b1, 1'b0, 32'h600);
    wait_done(lat, en, we, a, w);
    check("post_rst_lat", 32'(lat), 32'(LAT + 2));
    @(posedge clk); #1;
    d_req = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 32: address and data width.
REQ-002 Parameter LAT, default 2: unified-memory access latency in cycles; legal range 1..15.
REQ-003 Parameter STARVE, default 2: consecutive lost arbitrations after which instruction fetch wins; legal range 1..7.
REQ-004 ctrl_bus.clk  input  1  single clock; all state updates on its rising edge.
REQ-005 ctrl_bus.reset  input  1  reset, synchronous and active-low.
REQ-006 i_req  input  1  instruction fetch request; held until i_ready.
REQ-007 i_addr  input  N  fetch address; stable while i_req is high.
REQ-008 i_rdata  output  N  fetched word; valid when i_ready is high, held until the next fetch completes.
REQ-009 i_ready  output  1  one-cycle fetch-complete pulse.
REQ-010 d_req  input  1  data request; held until d_ready.
REQ-011 d_we  input  1  1 = store, 0 = load; stable while d_req is high.
REQ-012 d_addr  input  N  data address (ALU result).
REQ-013 d_wdata  input  N  store data.
REQ-014 d_rdata  output  N  load data; valid when d_ready is high after a load, held otherwise.
REQ-015 d_ready  output  1  one-cycle data-complete pulse, for both loads and stores.
REQ-016 m_en  output  1  memory access strobe.
REQ-017 m_we  output  1  memory write enable.
REQ-018 m_addr  output  N  memory address.
REQ-019 m_wdata  output  N  memory write data.
REQ-020 m_rdata  input  N  memory read data; valid in the last cycle of ACCESS.
REQ-021 busy  output  1  high in the ACCESS and DONE states.

Function
REQ-022 FSM states: IDLE, ACCESS, DONE. Transitions:
- IDLE -> ACCESS when i_req or d_req is high.
- ACCESS -> DONE when the down-counter equals 0.
- DONE -> IDLE unconditionally.
REQ-023 Arbitration happens in IDLE only.
- Data wins by default.
- Fetch wins when the starvation counter equals STARVE.
- A sole requester always wins.
REQ-024 Starvation counter behaviour:
- Increments when d wins while i_req is high.
- Clears when i wins.
- Saturates at STARVE.
- Unchanged when there is no contention.
REQ-025 On grant, the winner's addr, we and wdata are latched, together with an owner flag. m_* outputs are driven only from these latched values. Fetch grants force we = 0.
REQ-026 On entry to ACCESS the down-counter loads LAT-1 and decrements each ACCESS cycle.
REQ-027 m_en is high in every ACCESS cycle and low otherwise.
REQ-028 m_we equals the latched we during ACCESS and is 0 otherwise.
REQ-029 m_addr and m_wdata hold their latched values in all states.
REQ-030 In the last ACCESS cycle of a load or fetch, m_rdata is registered into the owner's rdata output. The other port's rdata is unchanged. Stores leave d_rdata unchanged.
REQ-031 The owner's ready output is high for exactly the one DONE cycle. The non-owner's ready stays 0. i_ready and d_ready are never high together.
REQ-032 Latency: a request sampled in IDLE at edge T gives ready high in cycle T+LAT+1, so one access occupies LAT+2 cycles.
REQ-033 Requesters drop req in the cycle after ready. A req still high in IDLE is treated as a new request.
REQ-034 Request changes during ACCESS or DONE are ignored; no preemption.
REQ-035 Simultaneous i_req and d_req in IDLE are resolved by REQ-023. The loser stays pending and is granted in the next IDLE cycle if still asserted.

Reset
REQ-036 When ctrl_bus.reset is low at a clock edge, the following are set:
- state = IDLE
- counter = 0
- starvation counter = 0
- owner = fetch
- latched addr, we and wdata = 0
- i_rdata and d_rdata = 0
REQ-037 Consequently, after reset i_ready, d_ready, m_en, m_we, busy = 0 and m_addr, m_wdata = 0.
REQ-038 Reset during ACCESS or DONE aborts the access: no ready pulse and no rdata update. The store write strobe stops at that edge.
REQ-039 Requests are not sampled during the reset cycle. Arbitration resumes in the first IDLE cycle after release.

Verification (LAT=2, STARVE=2)
REQ-040 Lone fetch: i_req=1, i_addr=0x40, m_rdata=0x8C010004 -> m_en high 2 cycles with m_addr=0x40 and m_we=0; i_ready pulses 3 cycles after grant; i_rdata=0x8C010004.
REQ-041 Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> m_we=1 for 2 cycles with those values; d_ready pulses once; d_rdata unchanged.
REQ-042 Contention: i_req and d_req high together, d_we=0, d_addr=0x200 -> data served first (d_ready), then fetch granted in the next IDLE; total 8 cycles for both.
REQ-043 Starvation: i_req held high with d_req re-asserted every IDLE -> d wins twice, fetch wins the third arbitration, then the starvation counter clears.
REQ-044 Reset mid-access: assert reset in the 2nd ACCESS cycle of a load -> next cycle IDLE with m_en=0, no d_ready pulse, and d_rdata=0.
